// File: rtl/gray_decode_arbiter_pkg.sv
// gray_decode_arbiter_pkg: shared defaults, channel-index width and legal Gray step deltas
package gray_decode_arbiter_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NCH   = 4;

    // A channel may hold, count up by one or count down by one (modulo 2^WIDTH)
    localparam int STEP_HOLD = 0;
    localparam int STEP_UP   = 1;
    localparam int STEP_DOWN = -1;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gray_decode_arbiter_core.sv
// gray2bin_core: combinational Gray-to-binary conversion
module gray2bin_core
    import gray_decode_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // Each binary bit is the XOR of the Gray bits at and above it
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        assign o_bin[g] = ^(i_gray >> g);
    end

endmodule

// File: rtl/gray_decode_arbiter.sv
// gray_decode_arbiter: round-robin grant of Gray samples, conversion to binary and per-channel step checking
module gray_decode_arbiter
    import gray_decode_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    localparam int CW   = chan_w(NCH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     req_valid,
    input  logic [NCH*WIDTH-1:0] req_gray,
    output logic [NCH-1:0]     req_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   binary_no,
    output logic [CW-1:0]      out_chan,
    output logic               out_first,
    output logic               out_step_err
);

    logic [CW-1:0]    r_ptr;
    logic             r_valid;
    logic [WIDTH-1:0] r_bin;
    logic [CW-1:0]    r_chan;
    logic             r_first;
    logic             r_err;
    logic [WIDTH-1:0] r_last [NCH];
    logic [NCH-1:0]   r_seen;

    logic             w_free;
    logic             w_any;
    logic             w_fire;
    logic [CW-1:0]    w_idx;
    logic [CW-1:0]    w_gnt_idx;
    logic [WIDTH-1:0] w_gray_arr [NCH];
    logic [WIDTH-1:0] w_sel_gray;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_delta;
    logic             w_step_err;

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign w_gray_arr[g] = req_gray[g*WIDTH +: WIDTH];
    end

    assign w_free = !r_valid || out_ready;

    // Round-robin search: first valid channel at or above the pointer, wrapping
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        for (int i = 0; i < NCH; i++) begin
            w_idx = r_ptr + CW'(i);
            if (!w_any && req_valid[w_idx]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
    end

    assign req_ready  = (w_free && w_any && !rst) ? (NCH'(1) << w_gnt_idx) : '0;
    assign w_fire     = |(req_valid & req_ready);
    assign w_sel_gray = w_gray_arr[w_gnt_idx];

    gray2bin_core #(.WIDTH(WIDTH)) u_core (
        .i_gray (w_sel_gray),
        .o_bin  (w_bin)
    );

    assign w_delta    = w_bin - r_last[w_gnt_idx];
    assign w_step_err = r_seen[w_gnt_idx] && !(w_delta == WIDTH'(STEP_HOLD) ||
                        w_delta == WIDTH'(STEP_UP) || w_delta == WIDTH'(STEP_DOWN));

    // Output register, pointer advance and per-channel history update on each accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_bin   <= '0;
            r_chan  <= '0;
            r_first <= 1'b0;
            r_err   <= 1'b0;
            r_seen  <= '0;
            for (int i = 0; i < NCH; i++) r_last[i] <= '0;
        end else if (w_fire) begin
            r_ptr              <= w_gnt_idx + CW'(1);
            r_valid            <= 1'b1;
            r_bin              <= w_bin;
            r_chan             <= w_gnt_idx;
            r_first            <= !r_seen[w_gnt_idx];
            r_err              <= w_step_err;
            r_last[w_gnt_idx]  <= w_bin;
            r_seen[w_gnt_idx]  <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid    = r_valid;
    assign binary_no    = r_bin;
    assign out_chan     = r_chan;
    assign out_first    = r_first;
    assign out_step_err = r_err;

endmodule
